// File: rtl/data_memory_sized_if.sv
// Request/response bus between the MEM stage and data_memory_sized.
// The master issues valid/ready requests; the slave returns a registered one-cycle response.
interface data_memory_sized_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressable little-endian data memory with power-on clear and range checking.
// Define DMEM_MISALIGN_TRAP_EN to reject accesses whose address is not a multiple of the access size.
module data_memory_sized #(
    parameter int DEPTH_BYTES    = 512,
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                clk,
    input logic                reset,
    data_memory_sized_if.slave bus
);
    localparam int NBW   = DATA_W / 8;
    localparam int WORDS = DEPTH_BYTES / NBW;
    localparam int CW    = $clog2(WORDS);
    localparam int LB    = $clog2(NBW);
    localparam int AW    = $clog2(DEPTH_BYTES);
    localparam int EW    = ADDR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    logic [7:0]        mem [DEPTH_BYTES];
    state_t            state;
    logic [CW-1:0]     clr_cnt;
    logic              ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic [3:0]        nbytes;
    logic [EW-1:0]     end_addr;
    logic [AW-1:0]     base;
    logic              range_err;
    logic              size_err;
    logic              align_err;
    logic              req_err;
    logic              accept;
    logic              do_store;
    logic              sign_fill;
    logic [63:0]       wdata64;
    logic [63:0]       raw;
    logic [63:0]       ext;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Decode, range check and the little-endian read path for the current request.
    always_comb begin
        nbytes    = 4'd1 << bus.req_size;
        end_addr  = {1'b0, bus.req_addr} + EW'(nbytes);
        range_err = end_addr > EW'(DEPTH_BYTES);
        size_err  = (DATA_W == 32) && (bus.req_size == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
        align_err = (bus.req_addr[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
`else
        align_err = 1'b0;
`endif
        req_err  = range_err | size_err | align_err;
        accept   = bus.req_valid & ready_q;
        do_store = accept & bus.req_we & ~req_err & ~reset;
        base     = bus.req_addr[AW-1:0];
        wdata64  = 64'(bus.req_wdata);

        raw = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                raw[8*i +: 8] = mem[base + AW'(i)];
            end
        end

        ext = raw;
        case (bus.req_size)
            2'd0: begin
                sign_fill = ~bus.req_unsigned & raw[7];
                ext       = {{56{sign_fill}}, raw[7:0]};
            end
            2'd1: begin
                sign_fill = ~bus.req_unsigned & raw[15];
                ext       = {{48{sign_fill}}, raw[15:0]};
            end
            2'd2: begin
                sign_fill = ~bus.req_unsigned & raw[31];
                ext       = {{32{sign_fill}}, raw[31:0]};
            end
            default: begin
                sign_fill = 1'b0;
                ext       = raw;
            end
        endcase
    end

    // The clear sequencer owns the array while clearing; otherwise only accepted stores write.
    always_ff @(posedge clk) begin
        if (!reset && state == ST_CLEAR) begin
            for (int i = 0; i < NBW; i++) begin
                mem[{clr_cnt, LB'(i)}] <= 8'h00;
            end
        end else if (do_store) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem[base + AW'(i)] <= wdata64[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt     <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= accept;
            rsp_err_q   <= accept & req_err;
            rsp_rdata_q <= (accept & ~bus.req_we & ~req_err) ? ext[DATA_W-1:0] : '0;
            case (state)
                ST_CLEAR: begin
                    ready_q <= 1'b0;
                    clr_cnt <= clr_cnt + CW'(1);
                    if (clr_cnt == CW'(WORDS - 1)) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized: directed scenarios plus randomized traffic
// compared against a byte-array reference model.
module tb_data_memory_sized;
    localparam int DEPTH  = 512;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic clk;
    logic reset;
    int   numChecks;
    int   numFails;
    logic [7:0] ref_mem [DEPTH];

    data_memory_sized_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

    data_memory_sized #(
        .DEPTH_BYTES(DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: plain byte array, range and alignment rules as arithmetic.
    function automatic logic modelErr(input logic [63:0] addr, input logic [1:0] size);
        longint unsigned n;
        n = longint'(1) << size;
        if (addr >= 64'(DEPTH)) return 1'b1;
        if (addr + n > 64'(DEPTH)) return 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((addr % n) != 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [63:0] modelLoad(input logic [63:0] addr, input logic [1:0] size, input logic uns);
        logic [63:0] v;
        int n;
        n = 1 << size;
        v = 64'd0;
        for (int i = 0; i < n; i++) begin
            v = v | (64'(ref_mem[int'(addr) + i]) << (8 * i));
        end
        if (!uns && n < 8 && v[8*n-1]) begin
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        end
        return v;
    endfunction

    task automatic modelStore(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] wdata);
        for (int i = 0; i < (1 << size); i++) begin
            ref_mem[int'(addr) + i] = wdata[8*i +: 8];
        end
    endtask

    // Drives one request for exactly one accept edge and checks the response after it.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [63:0] addr, input logic [63:0] wdata);
        logic        exp_err;
        logic [63:0] exp_data;
        checkOutput("req_ready", 64'(bus_if.req_ready), 64'd1);
        bus_if.req_valid    = 1'b1;
        bus_if.req_we       = we;
        bus_if.req_size     = size;
        bus_if.req_unsigned = uns;
        bus_if.req_addr     = addr;
        bus_if.req_wdata    = wdata;
        @(posedge clk);
        #1;
        exp_err  = modelErr(addr, size);
        exp_data = (we || exp_err) ? 64'd0 : modelLoad(addr, size, uns);
        checkOutput("rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
        checkOutput("rsp_err", 64'(bus_if.rsp_err), 64'(exp_err));
        checkOutput("rsp_rdata", bus_if.rsp_rdata, exp_data);
        if (we && !exp_err) modelStore(addr, size, wdata);
    endtask

    task automatic idleCycle();
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_valid", 64'(bus_if.rsp_valid), 64'd0);
        checkOutput("idle_err", 64'(bus_if.rsp_err), 64'd0);
        checkOutput("idle_rdata", bus_if.rsp_rdata, 64'd0);
    endtask

    task automatic waitReady(input string tag);
        int lowCycles;
        lowCycles = 0;
        while (!bus_if.req_ready && lowCycles < 200) begin
            lowCycles++;
            @(posedge clk);
            #1;
        end
        checkOutput(tag, 64'(lowCycles), 64'd64);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    task automatic pulseReset();
        reset            = 1'b1;
        bus_if.req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_valid", 64'(bus_if.rsp_valid), 64'd0);
        checkOutput("rst_ready", 64'(bus_if.req_ready), 64'd0);
    endtask

    initial begin
        logic [63:0] addr;
        logic [1:0]  size;
        numChecks           = 0;
        numFails            = 0;
        reset               = 1'b1;
        bus_if.req_valid    = 1'b0;
        bus_if.req_we       = 1'b0;
        bus_if.req_size     = 2'd0;
        bus_if.req_unsigned = 1'b0;
        bus_if.req_addr     = '0;
        bus_if.req_wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 64'(bus_if.req_ready), 64'd0);
        checkOutput("reset_valid", 64'(bus_if.rsp_valid), 64'd0);
        reset = 1'b0;

        $display("[TB] clear after reset and first load");
        waitReady("clear_len");
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h100, 64'd0);
        checkOutput("t1_ld", bus_if.rsp_rdata, 64'd0);

        $display("[TB] store double then sized loads");
        applyStimulus(1'b1, 2'd3, 1'b0, 64'h100, 64'h8877665544332211);
        applyStimulus(1'b0, 2'd0, 1'b0, 64'h107, 64'd0);
        checkOutput("t2_lb", bus_if.rsp_rdata, 64'hFFFFFFFFFFFFFF88);
        applyStimulus(1'b0, 2'd0, 1'b1, 64'h107, 64'd0);
        checkOutput("t2_lbu", bus_if.rsp_rdata, 64'h88);
        applyStimulus(1'b0, 2'd1, 1'b0, 64'h100, 64'd0);
        checkOutput("t2_lh", bus_if.rsp_rdata, 64'h2211);
        applyStimulus(1'b0, 2'd2, 1'b0, 64'h104, 64'd0);
        checkOutput("t2_lw", bus_if.rsp_rdata, 64'hFFFFFFFF88776655);

        $display("[TB] store then load back-to-back");
        applyStimulus(1'b1, 2'd2, 1'b0, 64'h104, 64'h7);
        applyStimulus(1'b0, 2'd2, 1'b0, 64'h104, 64'd0);
        checkOutput("t3_lw", bus_if.rsp_rdata, 64'h7);
        idleCycle();

        $display("[TB] range errors");
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h1FC, 64'd0);
        checkOutput("t4_ld_err", 64'(bus_if.rsp_err), 64'd1);
        applyStimulus(1'b1, 2'd0, 1'b0, 64'h200, 64'hAB);
        checkOutput("t4_sb_err", 64'(bus_if.rsp_err), 64'd1);
        applyStimulus(1'b0, 2'd0, 1'b1, 64'h0, 64'd0);
        applyStimulus(1'b1, 2'd1, 1'b0, 64'h8000_0000_0000_0100, 64'hBEEF);
        applyStimulus(1'b0, 2'd1, 1'b1, 64'h100, 64'd0);

        $display("[TB] misaligned word");
        applyStimulus(1'b0, 2'd2, 1'b0, 64'h102, 64'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("t5_err", 64'(bus_if.rsp_err), 64'd1);
        checkOutput("t5_rdata", bus_if.rsp_rdata, 64'd0);
`else
        checkOutput("t5_err", 64'(bus_if.rsp_err), 64'd0);
        checkOutput("t5_rdata", bus_if.rsp_rdata, 64'h0000000000074433);
`endif

        $display("[TB] reset during pending response and mid-clear");
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h100, 64'd0);
        pulseReset();
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t6_midclear_ready", 64'(bus_if.req_ready), 64'd0);
        pulseReset();
        waitReady("t6_clear_len");
        applyStimulus(1'b0, 2'd3, 1'b0, 64'h100, 64'd0);
        checkOutput("t6_cleared", bus_if.rsp_rdata, 64'd0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idleCycle();
            end else begin
                size = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 9))
                    0:       addr = {32'($urandom), 32'($urandom)};
                    1, 2:    addr = 64'($urandom_range(DEPTH - 8, DEPTH + 8));
                    3, 4, 5: addr = 64'($urandom_range(0, DEPTH - 1));
                    default: addr = 64'($urandom_range(32'h100, 32'h11F));
                endcase
                applyStimulus(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)),
                              addr, {32'($urandom), 32'($urandom)});
            end
        end
        idleCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule
